call_trace_stack: RTL and testbench

Hardware consumer of the core's function-trace event stream (call/ret events emitted by the PC update stage on each control transfer). Maintains a shadow stack of return addresses and reports return-address mismatches, underflow and overflow. Includes a dump engine that streams the live stack to the simulation host on request. Sits beside the single-cycle core; it observes the core and never stalls or alters its PC path.

---
 rtl/call_trace_stack_pkg.sv | 18 +
 rtl/ret_addr_ram.sv | 30 +++
 rtl/call_trace_stack.sv | 200 ++++++++++++++++++++
 tb/tb_call_trace_stack.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/call_trace_stack_pkg.sv
// Shared encodings for the call/return trace shadow stack.
package call_trace_stack_pkg;

    // Trace event kinds; any other encoding is accepted and ignored.
    localparam logic [1:0] EV_CALL = 2'b01;
    localparam logic [1:0] EV_RET  = 2'b10;

    // Byte offset from a call instruction to its return address.
    localparam int INST_BYTES_DEF = 4;

    // Dump engine states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DUMP       = 2'd1,
        DUMP_EMPTY = 2'd2
    } dump_state_t;

endpackage

// File: rtl/ret_addr_ram.sv
// Return-address storage: one synchronous write port, two asynchronous reads
// (top of stack for ret compares, and the dump pointer). Contents are not reset.
module ret_addr_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      top_addr,
    output logic [DATA_WIDTH-1:0] top_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Single write port, driven by accepted call events.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data = mem[top_addr];
    assign rd_data  = mem[rd_addr];

endmodule

// File: rtl/call_trace_stack.sv
// Shadow return-address stack fed by the core's call/ret trace stream.
// Flags return mismatches, underflow and overflow losses, and can stream
// the live stack (newest first) to the host.
//
// Handshakes: an event transfers on a clock edge where ev_valid && ev_ready;
// a dump beat transfers on an edge where dump_valid && dump_ready. Once
// raised, dump_valid stays high and dump_data stays constant until the beat
// transfers.
module call_trace_stack
    import call_trace_stack_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int INST_BYTES = INST_BYTES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [1:0]                ev_type,
    input  logic [DATA_WIDTH-1:0]     ev_pc,
    input  logic [DATA_WIDTH-1:0]     ev_target,
    output logic [$clog2(DEPTH):0]    depth,
    output logic [15:0]               lost_cnt,
    output logic                      mismatch,
    output logic [DATA_WIDTH-1:0]     exp_addr,
    output logic [DATA_WIDTH-1:0]     act_addr,
    output logic                      underflow,
    input  logic                      dump_req,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [DATA_WIDTH-1:0]     dump_data,
    output logic                      dump_last
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO_CNT  = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

    dump_state_t           state;
    logic [PTR_W-1:0]      wp;
    logic [PTR_W-1:0]      rp;
    logic [PTR_W:0]        remaining;

    logic                  is_call;
    logic                  is_ret;
    logic [DATA_WIDTH-1:0] ret_addr;
    logic [PTR_W-1:0]      nxt_wp;
    logic [PTR_W:0]        nxt_depth;
    logic [15:0]           nxt_lost;
    logic                  do_mis;
    logic                  do_under;
    logic [PTR_W-1:0]      top_addr;
    logic [DATA_WIDTH-1:0] top_data;
    logic [PTR_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] snap_data;

    // Events are only taken while the dump engine is idle.
    assign ev_ready = (state == IDLE);
    assign top_addr = wp - ONE_PTR;

    ret_addr_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we       (is_call && !flush),
        .waddr    (wp),
        .wdata    (ret_addr),
        .top_addr (top_addr),
        .top_data (top_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Post-event stack state, plus the dump snapshot of the new top entry.
    always_comb begin
        is_call   = ev_valid && ev_ready && (ev_type == EV_CALL);
        is_ret    = ev_valid && ev_ready && (ev_type == EV_RET);
        ret_addr  = ev_pc + DATA_WIDTH'(INST_BYTES);
        nxt_wp    = wp;
        nxt_depth = depth;
        nxt_lost  = lost_cnt;
        do_mis    = 1'b0;
        do_under  = 1'b0;
        if (is_call) begin
            nxt_wp = wp + ONE_PTR;
            if (depth == FULL_CNT) begin
                if (lost_cnt != 16'hFFFF) begin
                    nxt_lost = lost_cnt + 16'd1;
                end
            end else begin
                nxt_depth = depth + ONE_CNT;
            end
        end else if (is_ret) begin
            if (depth != '0) begin
                nxt_wp    = wp - ONE_PTR;
                nxt_depth = depth - ONE_CNT;
                do_mis    = (ev_target != top_data);
            end else if (lost_cnt != 16'd0) begin
                nxt_lost = lost_cnt - 16'd1;
            end else begin
                do_under = 1'b1;
            end
        end
        // While dumping, prefetch the next beat; when idle, look at the new top.
        rd_addr   = (state == DUMP) ? (rp - ONE_PTR) : (nxt_wp - ONE_PTR);
        // A call in the same cycle has not reached the RAM yet, so bypass it.
        snap_data = is_call ? ret_addr : rd_data;
    end

    // Stack bookkeeping, mismatch reporting and the dump engine FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            remaining  <= '0;
            depth      <= '0;
            lost_cnt   <= '0;
            mismatch   <= 1'b0;
            exp_addr   <= '0;
            act_addr   <= '0;
            underflow  <= 1'b0;
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_data  <= '0;
        end else if (flush) begin
            wp         <= '0;
            depth      <= '0;
            lost_cnt   <= '0;
            mismatch   <= 1'b0;
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            wp       <= nxt_wp;
            depth    <= nxt_depth;
            lost_cnt <= nxt_lost;
            mismatch <= do_mis;
            if (do_mis) begin
                exp_addr <= top_data;
                act_addr <= ev_target;
            end
            if (do_under) begin
                underflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        dump_valid <= 1'b1;
                        if (nxt_depth != '0) begin
                            state     <= DUMP;
                            rp        <= nxt_wp - ONE_PTR;
                            remaining <= nxt_depth;
                            dump_data <= snap_data;
                            dump_last <= (nxt_depth == ONE_CNT);
                        end else begin
                            state     <= DUMP_EMPTY;
                            dump_data <= '0;
                            dump_last <= 1'b1;
                        end
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (remaining == ONE_CNT) begin
                            state      <= IDLE;
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                        end else begin
                            rp        <= rp - ONE_PTR;
                            remaining <= remaining - ONE_CNT;
                            dump_data <= rd_data;
                            dump_last <= (remaining == TWO_CNT);
                        end
                    end
                end
                DUMP_EMPTY: begin
                    if (dump_ready) begin
                        state      <= IDLE;
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_trace_stack.sv
// Randomized scoreboard bench for call_trace_stack with a queue-based stack model.
module tb_call_trace_stack;
    import call_trace_stack_pkg::*;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int PW    = $clog2(DEPTH);

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_type;
    logic [DW-1:0] ev_pc;
    logic [DW-1:0] ev_target;
    logic [PW:0]   depth;
    logic [15:0]   lost_cnt;
    logic          mismatch;
    logic [DW-1:0] exp_addr;
    logic [DW-1:0] act_addr;
    logic          underflow;
    logic          dump_req;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic          dump_last;

    always #5 clk = ~clk;

    call_trace_stack #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .INST_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_type    (ev_type),
        .ev_pc      (ev_pc),
        .ev_target  (ev_target),
        .depth      (depth),
        .lost_cnt   (lost_cnt),
        .mismatch   (mismatch),
        .exp_addr   (exp_addr),
        .act_addr   (act_addr),
        .underflow  (underflow),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    // ---------------- reference model + scoreboards ----------------
    logic [DW-1:0]   m_stack[$];   // oldest at front, newest at back
    int              m_lost;
    bit              m_under;
    logic [2*DW-1:0] mis_q[$];     // {expected return addr, actual target}
    logic [DW:0]     exp_q[$];     // {last, data} per dump beat

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_lost  = 0;
        m_under = 0;
        mis_q.delete();
        exp_q.delete();
    endtask

    task automatic model_event(input logic [1:0] t, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
        logic [DW-1:0] top;
        if (t == EV_CALL) begin
            m_stack.push_back(pc + 32'd4);
            if (m_stack.size() > DEPTH) begin
                void'(m_stack.pop_front());
                if (m_lost < 65535) m_lost++;
            end
        end else if (t == EV_RET) begin
            if (m_stack.size() > 0) begin
                top = m_stack.pop_back();
                if (top != tgt) mis_q.push_back({top, tgt});
            end else if (m_lost > 0) begin
                m_lost--;
            end else begin
                m_under = 1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, 64'(depth), 64'(m_stack.size()));
        chk({tag, "_lost"}, 64'(lost_cnt), 64'(m_lost));
        chk({tag, "_underflow"}, 64'(underflow), 64'(m_under));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; ev_valid = 1'b0; ev_type = 2'b00;
        ev_pc = '0; ev_target = '0; dump_req = 1'b0; dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        #1 rst = 1'b0;
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_lost", 64'(lost_cnt), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_mismatch", 64'(mismatch), 64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_ev_ready", 64'(ev_ready), 64'd1);
        chk("rst_exp_addr", 64'(exp_addr), 64'd0);
    endtask

    task automatic send_ev(input logic [1:0] t, input logic [DW-1:0] pc, input logic [DW-1:0] tgt, input bit fl);
        int n = 0;
        ev_valid = 1'b1; ev_type = t; ev_pc = pc; ev_target = tgt; flush = fl;
        while (!ev_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!ev_ready) chk("ev_ready_timeout", 64'(ev_ready), 64'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0; flush = 1'b0;
        if (fl) begin
            m_stack.delete();
            m_lost = 0;
        end else begin
            model_event(t, pc, tgt);
        end
    endtask

    // mode 0: ready toggles 1/0, 1: random ready, 2: always ready
    task automatic do_dump(input int mode, input bit with_call, input logic [DW-1:0] pc);
        int  cyc = 0;
        bit  done = 0;
        bit  tog = 1;
        dump_req = 1'b1;
        if (with_call) begin
            ev_valid = 1'b1; ev_type = EV_CALL; ev_pc = pc;
        end
        @(posedge clk);
        #1;
        dump_req = 1'b0; ev_valid = 1'b0;
        if (with_call) model_event(EV_CALL, pc, '0);
        if (m_stack.size() == 0) begin
            exp_q.push_back({1'b1, {DW{1'b0}}});
        end else begin
            for (int i = m_stack.size() - 1; i >= 0; i--)
                exp_q.push_back({(i == 0), m_stack[i]});
        end
        while (!done && cyc < 200) begin
            case (mode)
                0: dump_ready = tog;
                1: dump_ready = ($urandom_range(0, 2) != 0);
                default: dump_ready = 1'b1;
            endcase
            tog = !tog;
            @(negedge clk);
            chk("dump_ev_ready", 64'(ev_ready), 64'd0);
            if (dump_valid && dump_ready && dump_last) done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_done", 64'(done), 64'd1);
        chk("dump_beats_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("dump_idle_ev_ready", 64'(ev_ready), 64'd1);
    endtask

    // ---------------- monitor ----------------
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        logic [2*DW-1:0] me;
        logic [DW:0]     be;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("dump_hold_valid", 64'(dump_valid), 64'd1);
                chk("dump_hold_data", 64'(dump_data), 64'(prev_data));
            end
            if (mismatch) begin
                if (mis_q.size() == 0) begin
                    chk("mismatch_unexpected", 64'(mismatch), 64'd0);
                end else begin
                    me = mis_q.pop_front();
                    chk("mis_exp_addr", 64'(exp_addr), 64'(me[2*DW-1:DW]));
                    chk("mis_act_addr", 64'(act_addr), 64'(me[DW-1:0]));
                end
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    chk("dump_beat_unexpected", 64'(dump_valid), 64'd0);
                end else begin
                    be = exp_q.pop_front();
                    chk("dump_data", 64'(dump_data), 64'(be[DW-1:0]));
                    chk("dump_last", 64'(dump_last), 64'(be[DW]));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] tgt;
        int r;
        do_reset();

        // Matching call/ret pair.
        send_ev(EV_CALL, 32'h8000_0000, 32'h8000_0100, 0);
        check_state("pair_call");
        send_ev(EV_RET, 32'h8000_0100, 32'h8000_0004, 0);
        check_state("pair_ret");

        // Mismatching ret.
        send_ev(EV_CALL, 32'h8000_0010, 32'h8000_0200, 0);
        send_ev(EV_RET, 32'h8000_0200, 32'h8000_0020, 0);
        check_state("mis_ret");
        repeat (2) @(posedge clk);
        #1;
        chk("mis_pending", 64'(mis_q.size()), 64'd0);
        chk("mis_pulse_gone", 64'(mismatch), 64'd0);

        // Overflow and unwinding of lost entries.
        for (int i = 0; i < DEPTH + 2; i++)
            send_ev(EV_CALL, 32'h1000 + 32'(16 * i), 32'h9000, 0);
        chk("ovf_depth", 64'(depth), 64'(DEPTH));
        chk("ovf_lost", 64'(lost_cnt), 64'd2);
        for (int i = DEPTH + 1; i >= 0; i--) begin
            send_ev(EV_RET, 32'h9000, 32'h1000 + 32'(16 * i) + 32'd4, 0);
            check_state("unwind");
        end

        // Three-entry dump with toggling ready.
        for (int i = 0; i < 3; i++)
            send_ev(EV_CALL, 32'h2000 + 32'(8 * i), 32'h3000, 0);
        do_dump(0, 0, '0);
        check_state("post_dump");

        // Call dropped by flush, then empty dump.
        send_ev(EV_CALL, 32'h4000, 32'h5000, 1);
        check_state("flush");
        do_dump(2, 0, '0);

        // Call in the same cycle as the dump request.
        send_ev(EV_CALL, 32'h6000, 32'h7000, 0);
        do_dump(1, 1, 32'h6100);
        check_state("call_dump");

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                send_ev(EV_CALL, $urandom, $urandom, 0);
            end else if (r < 85) begin
                tgt = (m_stack.size() > 0 && $urandom_range(0, 3) != 0) ? m_stack[$] : $urandom;
                send_ev(EV_RET, $urandom, tgt, 0);
            end else if (r < 90) begin
                send_ev(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, $urandom, $urandom, 0);
            end else if (r < 93) begin
                send_ev(EV_CALL, $urandom, $urandom, 1);
            end else if (r < 96) begin
                do_dump($urandom_range(0, 2), $urandom_range(0, 1), $urandom);
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            check_state("rand");
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rand_mis_pending", 64'(mis_q.size()), 64'd0);

        // Reset in the middle of a stalled dump.
        for (int i = 0; i < 3; i++)
            send_ev(EV_CALL, 32'h2000 + 32'(8 * i), 32'h3000, 0);
        dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("middump_valid", 64'(dump_valid), 64'd1);
        do_reset();
        chk("middump_rst_valid", 64'(dump_valid), 64'd0);
        chk("middump_rst_last", 64'(dump_last), 64'd0);
        chk("middump_rst_data", 64'(dump_data), 64'd0);

        // Underflow is sticky across later valid traffic.
        send_ev(EV_RET, 32'h100, 32'h200, 0);
        check_state("uflow");
        chk("uflow_set", 64'(underflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            send_ev(EV_CALL, 32'h500 + 32'(i), 32'h0, 0);
            send_ev(EV_RET, 32'h0, 32'h504 + 32'(i), 0);
            check_state("uflow_pair");
        end
        chk("uflow_sticky", 64'(underflow), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("final_mis_pending", 64'(mis_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
